// File: rtl/conv_feeder_if.sv
// conv_feeder_if: operand and stream bundle between the operand store,
// conv_feeder and the downstream 4-lane systolic array.
//   start, hold     : run request / downstream back-pressure
//   a00..a33        : 4x4 input tile, row-major a<row><col>
//   b00..b22        : 3x3 filter, b<row><col>
//   act0..act3      : per-lane activation
//   wgt0..wgt3      : per-lane weight
//   vld, clr, lst   : per-lane valid / first-tap / last-tap strobes
//   busy, done      : run in progress / one-cycle completion pulse
// master drives the operands and requests; slave is the feeder itself.
interface conv_feeder_if #(
   parameter int DW = 8
);
   logic          start;
   logic          hold;
   logic [DW-1:0] a00, a01, a02, a03;
   logic [DW-1:0] a10, a11, a12, a13;
   logic [DW-1:0] a20, a21, a22, a23;
   logic [DW-1:0] a30, a31, a32, a33;
   logic [DW-1:0] b00, b01, b02;
   logic [DW-1:0] b10, b11, b12;
   logic [DW-1:0] b20, b21, b22;
   logic [DW-1:0] act0, act1, act2, act3;
   logic [DW-1:0] wgt0, wgt1, wgt2, wgt3;
   logic [3:0]    vld;
   logic [3:0]    clr;
   logic [3:0]    lst;
   logic          busy;
   logic          done;

   modport master (
      output start, hold,
      output a00, a01, a02, a03, a10, a11, a12, a13,
      output a20, a21, a22, a23, a30, a31, a32, a33,
      output b00, b01, b02, b10, b11, b12, b20, b21, b22,
      input  act0, act1, act2, act3, wgt0, wgt1, wgt2, wgt3,
      input  vld, clr, lst, busy, done
   );

   modport slave (
      input  start, hold,
      input  a00, a01, a02, a03, a10, a11, a12, a13,
      input  a20, a21, a22, a23, a30, a31, a32, a33,
      input  b00, b01, b02, b10, b11, b12, b20, b21, b22,
      output act0, act1, act2, act3, wgt0, wgt1, wgt2, wgt3,
      output vld, clr, lst, busy, done
   );
endinterface

// File: rtl/conv_feeder.sv
// conv_feeder: snapshots a 4x4 tile and a 3x3 filter on start and streams
// them, skewed by one step per lane, into a 4-lane output-stationary
// systolic array computing the 2x2 valid convolution.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : conv_feeder_if.slave (operands, start/hold in; lane streams,
//          strobes and run status out, all registered)
// Lane p computes pixel (p/2, p%2); at step n it carries tap k = n - p.
module conv_feeder #(
   parameter int DW    = 8,
   parameter int NSTEP = 12
) (
   input  logic          clk,
   input  logic          rst,
   conv_feeder_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_STEP = 4'(NSTEP - 1);

   state_t        state_r, state_s;
   logic [3:0]    n_r, n_s;
   logic [DW-1:0] a_in_s [16];
   logic [DW-1:0] b_in_s [9];
   logic [DW-1:0] a_r [16];
   logic [DW-1:0] b_r [9];
   logic [DW-1:0] act_r [4];
   logic [DW-1:0] act_s [4];
   logic [DW-1:0] wgt_r [4];
   logic [DW-1:0] wgt_s [4];
   logic [3:0]    vld_r, vld_s;
   logic [3:0]    clr_r, clr_s;
   logic [3:0]    lst_r, lst_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          last_s;

   // Lane p is active at step n when its tap k = n - p lies in 0..8.
   function automatic logic lane_on(input logic [3:0] n, input logic [1:0] p);
      logic [3:0] k;
      k = n - {2'b00, p};
      return (n >= {2'b00, p}) && (k <= 4'd8);
   endfunction

   function automatic logic [3:0] lane_k(input logic [3:0] n, input logic [1:0] p);
      return n - {2'b00, p};
   endfunction

   // Flat tile index {row, col} of A[r+i][c+j] for lane p at tap k.
   function automatic logic [3:0] act_idx(input logic [3:0] k, input logic [1:0] p);
      logic [1:0] ti;
      logic [1:0] tj;
      logic [1:0] row;
      logic [1:0] col;
      case (k)
         4'd0:    begin ti = 2'd0; tj = 2'd0; end
         4'd1:    begin ti = 2'd0; tj = 2'd1; end
         4'd2:    begin ti = 2'd0; tj = 2'd2; end
         4'd3:    begin ti = 2'd1; tj = 2'd0; end
         4'd4:    begin ti = 2'd1; tj = 2'd1; end
         4'd5:    begin ti = 2'd1; tj = 2'd2; end
         4'd6:    begin ti = 2'd2; tj = 2'd0; end
         4'd7:    begin ti = 2'd2; tj = 2'd1; end
         4'd8:    begin ti = 2'd2; tj = 2'd2; end
         default: begin ti = 2'd0; tj = 2'd0; end
      endcase
      row = {1'b0, p[1]} + ti;
      col = {1'b0, p[0]} + tj;
      return {row, col};
   endfunction

   assign a_in_s[0]  = bus.a00;
   assign a_in_s[1]  = bus.a01;
   assign a_in_s[2]  = bus.a02;
   assign a_in_s[3]  = bus.a03;
   assign a_in_s[4]  = bus.a10;
   assign a_in_s[5]  = bus.a11;
   assign a_in_s[6]  = bus.a12;
   assign a_in_s[7]  = bus.a13;
   assign a_in_s[8]  = bus.a20;
   assign a_in_s[9]  = bus.a21;
   assign a_in_s[10] = bus.a22;
   assign a_in_s[11] = bus.a23;
   assign a_in_s[12] = bus.a30;
   assign a_in_s[13] = bus.a31;
   assign a_in_s[14] = bus.a32;
   assign a_in_s[15] = bus.a33;
   assign b_in_s[0]  = bus.b00;
   assign b_in_s[1]  = bus.b01;
   assign b_in_s[2]  = bus.b02;
   assign b_in_s[3]  = bus.b10;
   assign b_in_s[4]  = bus.b11;
   assign b_in_s[5]  = bus.b12;
   assign b_in_s[6]  = bus.b20;
   assign b_in_s[7]  = bus.b21;
   assign b_in_s[8]  = bus.b22;

   // Final step emitted this edge: STREAM, no bubble, counter on step 11.
   assign last_s = (state_r == ST_STREAM) && !bus.hold && (n_r == LAST_STEP);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so it never queues.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD:   state_s = ST_STREAM;
         ST_STREAM: begin
            if (last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_DONE:   state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Output logic: next values of the step counter and output registers.
   // act/wgt hold through bubbles and DONE; strobes drop to 0 there.
   always_comb begin
      n_s    = n_r;
      act_s  = act_r;
      wgt_s  = wgt_r;
      vld_s  = 4'b0000;
      clr_s  = 4'b0000;
      lst_s  = 4'b0000;
      busy_s = (state_s == ST_LOAD) || (state_s == ST_STREAM);
      done_s = last_s;
      case (state_r)
         ST_IDLE: begin
            n_s = n_r;
         end
         ST_LOAD: begin
            // Start every run from a clean output state.
            n_s = 4'd0;
            for (int p = 0; p < 4; p++) begin
               act_s[p] = '0;
               wgt_s[p] = '0;
            end
         end
         ST_STREAM: begin
            if (!bus.hold) begin
               n_s = n_r + 4'd1;
               for (int p = 0; p < 4; p++) begin
                  if (lane_on(n_r, 2'(p))) begin
                     act_s[p] = a_r[act_idx(lane_k(n_r, 2'(p)), 2'(p))];
                     wgt_s[p] = b_r[lane_k(n_r, 2'(p))];
                     vld_s[p] = 1'b1;
                     clr_s[p] = (lane_k(n_r, 2'(p)) == 4'd0);
                     lst_s[p] = (lane_k(n_r, 2'(p)) == 4'd8);
                  end else begin
                     act_s[p] = '0;
                     wgt_s[p] = '0;
                  end
               end
            end else begin
               n_s = n_r;
            end
         end
         ST_DONE: begin
            n_s = n_r;
         end
         default: begin
            n_s = 4'd0;
         end
      endcase
   end

   // Datapath registers: step counter, operand snapshot, lane outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_r    <= 4'd0;
         vld_r  <= 4'b0000;
         clr_r  <= 4'b0000;
         lst_r  <= 4'b0000;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         for (int i = 0; i < 16; i++) a_r[i] <= '0;
         for (int i = 0; i < 9; i++)  b_r[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            act_r[i] <= '0;
            wgt_r[i] <= '0;
         end
      end else begin
         n_r    <= n_s;
         vld_r  <= vld_s;
         clr_r  <= clr_s;
         lst_r  <= lst_s;
         busy_r <= busy_s;
         done_r <= done_s;
         act_r  <= act_s;
         wgt_r  <= wgt_s;
         // Snapshot once per run; later input changes are invisible.
         if (state_r == ST_LOAD) begin
            a_r <= a_in_s;
            b_r <= b_in_s;
         end
      end
   end

   assign bus.act0 = act_r[0];
   assign bus.act1 = act_r[1];
   assign bus.act2 = act_r[2];
   assign bus.act3 = act_r[3];
   assign bus.wgt0 = wgt_r[0];
   assign bus.wgt1 = wgt_r[1];
   assign bus.wgt2 = wgt_r[2];
   assign bus.wgt3 = wgt_r[3];
   assign bus.vld  = vld_r;
   assign bus.clr  = clr_r;
   assign bus.lst  = lst_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed bench for conv_feeder. Drives the reference
// tile/filter, checks strobes and operands at the documented edges, and
// accumulates act*wgt per lane to compare against hand-computed sums.
module tb_conv_feeder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   edge_no;
   int   done_cnt;
   int   acc [4];
   int   fin [4];
   logic [7:0] act_t [4];
   logic [7:0] wgt_t [4];

   localparam int A_G [16] = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
   localparam int B_G [9]  = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
   localparam int SUM_G [4] = '{67, 74, 34, 59};

   conv_feeder_if #(.DW(8)) bus ();

   conv_feeder #(.DW(8), .NSTEP(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign act_t[0] = bus.act0;
   assign act_t[1] = bus.act1;
   assign act_t[2] = bus.act2;
   assign act_t[3] = bus.act3;
   assign wgt_t[0] = bus.wgt0;
   assign wgt_t[1] = bus.wgt1;
   assign wgt_t[2] = bus.wgt2;
   assign wgt_t[3] = bus.wgt3;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-cycle monitor: lane accumulators, done count, busy/done exclusion.
   task automatic sample();
      for (int p = 0; p < 4; p++) begin
         if (bus.vld[p]) begin
            if (bus.clr[p]) acc[p] = int'(act_t[p]) * int'(wgt_t[p]);
            else            acc[p] = acc[p] + int'(act_t[p]) * int'(wgt_t[p]);
            if (bus.lst[p]) fin[p] = acc[p];
         end
      end
      if (bus.done) done_cnt++;
      check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_no++;
      sample();
   endtask

   task automatic clear_acc();
      for (int p = 0; p < 4; p++) begin
         acc[p] = 0;
         fin[p] = -1;
      end
      done_cnt = 0;
   endtask

   task automatic apply_ops(input bit zero);
      int av [16];
      int bv [9];
      for (int i = 0; i < 16; i++) av[i] = zero ? 0 : A_G[i];
      for (int i = 0; i < 9; i++)  bv[i] = zero ? 0 : B_G[i];
      bus.a00 = 8'(av[0]);  bus.a01 = 8'(av[1]);  bus.a02 = 8'(av[2]);  bus.a03 = 8'(av[3]);
      bus.a10 = 8'(av[4]);  bus.a11 = 8'(av[5]);  bus.a12 = 8'(av[6]);  bus.a13 = 8'(av[7]);
      bus.a20 = 8'(av[8]);  bus.a21 = 8'(av[9]);  bus.a22 = 8'(av[10]); bus.a23 = 8'(av[11]);
      bus.a30 = 8'(av[12]); bus.a31 = 8'(av[13]); bus.a32 = 8'(av[14]); bus.a33 = 8'(av[15]);
      bus.b00 = 8'(bv[0]);  bus.b01 = 8'(bv[1]);  bus.b02 = 8'(bv[2]);
      bus.b10 = 8'(bv[3]);  bus.b11 = 8'(bv[4]);  bus.b12 = 8'(bv[5]);
      bus.b20 = 8'(bv[6]);  bus.b21 = 8'(bv[7]);  bus.b22 = 8'(bv[8]);
   endtask

   // Pulse start across one edge (E0); edge_no counts edges after E0.
   task automatic start_run();
      bus.start = 1'b1;
      tick();
      edge_no = 0;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_edge);
      int guard;
      guard = 0;
      while (!bus.done && guard < 40) begin
         tick();
         guard++;
      end
      check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
      check({tag, "_done_edge"}, edge_no, exp_edge);
   endtask

   task automatic check_sums(input string tag);
      for (int p = 0; p < 4; p++) begin
         check($sformatf("%s_sum_lane%0d", tag, p), fin[p], SUM_G[p]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      edge_no  = 0;
      clear_acc();
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      apply_ops(1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", {28'd0, bus.vld}, 32'd0);
      check("rst_act0", {24'd0, bus.act0}, 32'd0);
      check("rst_wgt3", {24'd0, bus.wgt3}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b1;
      tick();

      // Basic run with edge-exact checks.
      clear_acc();
      start_run();
      check("e0_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      check("e1_vld", {28'd0, bus.vld}, 32'd0);
      check("e1_act0", {24'd0, bus.act0}, 32'd0);
      tick();
      check("e2_vld", {28'd0, bus.vld}, 32'b0001);
      check("e2_act0", {24'd0, bus.act0}, 32'd9);
      check("e2_wgt0", {24'd0, bus.wgt0}, 32'd3);
      check("e2_clr", {28'd0, bus.clr}, 32'b0001);
      repeat (3) tick();
      check("e5_vld", {28'd0, bus.vld}, 32'b1111);
      check("e5_act3", {24'd0, bus.act3}, 32'd4);
      check("e5_wgt3", {24'd0, bus.wgt3}, 32'd3);
      check("e5_clr", {28'd0, bus.clr}, 32'b1000);
      wait_done("basic", 13);
      check("e13_vld", {28'd0, bus.vld}, 32'b1000);
      check("e13_lst", {28'd0, bus.lst}, 32'b1000);
      check("e13_busy", {31'd0, bus.busy}, 32'd0);
      tick();
      check("e14_vld", {28'd0, bus.vld}, 32'd0);
      check("e14_lst", {28'd0, bus.lst}, 32'd0);
      check("e14_done", {31'd0, bus.done}, 32'd0);
      check("e14_busy", {31'd0, bus.busy}, 32'd0);
      check_sums("basic");
      check("basic_done_cnt", done_cnt, 1);

      // Three bubbles after step 4 (visible after E6).
      clear_acc();
      start_run();
      repeat (6) tick();
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_vld", {28'd0, bus.vld}, 32'd0);
         check("hold_act0", {24'd0, bus.act0}, 32'd4);
         check("hold_act3", {24'd0, bus.act3}, 32'd1);
         check("hold_wgt3", {24'd0, bus.wgt3}, 32'd2);
      end
      bus.hold = 1'b0;
      wait_done("hold", 16);
      tick();
      check_sums("hold");
      check("hold_done_cnt", done_cnt, 1);

      // Inputs zeroed and start re-pulsed mid-run.
      clear_acc();
      start_run();
      repeat (3) tick();
      apply_ops(1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("snap", 13);
      repeat (4) tick();
      check("snap_idle_busy", {31'd0, bus.busy}, 32'd0);
      check_sums("snap");
      check("snap_done_cnt", done_cnt, 1);
      apply_ops(1'b0);

      // Reset at step 6 (visible after E8).
      clear_acc();
      start_run();
      repeat (8) tick();
      check("pre_rst_vld", {28'd0, bus.vld}, 32'b1111);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_vld", {28'd0, bus.vld}, 32'd0);
      check("midrst_act0", {24'd0, bus.act0}, 32'd0);
      check("midrst_wgt2", {24'd0, bus.wgt2}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      tick();
      rst = 1'b1;
      check("midrst_done_cnt", done_cnt, 0);
      tick();
      clear_acc();
      start_run();
      wait_done("rerun", 13);
      tick();
      check_sums("rerun");

      // start held high: back-to-back runs.
      clear_acc();
      bus.start = 1'b1;
      tick();
      edge_no = 0;
      wait_done("b2b1", 13);
      tick();
      check("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
      check_sums("b2b1");
      clear_acc();
      tick();
      check("b2b_reload_busy", {31'd0, bus.busy}, 32'd1);
      edge_no = 0;
      wait_done("b2b2", 13);
      bus.start = 1'b0;
      tick();
      check_sums("b2b2");
      check("b2b2_done_cnt", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
